pio_seq: RTL and testbench

//  Sequences one ATA PIO register/data transfer: address setup (T1), strobe

---
 rtl/pio_pkg.sv | 16 +
 rtl/pio_seq_if.sv | 32 +++
 rtl/pio_tmr.sv | 40 ++++
 rtl/pio_seq.sv | 141 ++++++++++++++
 tb/tb_pio_seq.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the ATA PIO cycle sequencer.
package pio_pkg;

   // Default width of each timing value (phase length = value + 1 cycles).
   localparam int TWIDTH_DEF = 8;

   // Sequencer phases: address setup, strobe active, IORDY stretch, recovery.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_WAIT = 3'd3,
      ST_EOC  = 3'd4
   } pio_state_e;

endpackage

// File: rtl/pio_seq_if.sv
// Host/pin-side signal bundle of the PIO sequencer.
// master = host register logic and ATA pad side, slave = pio_seq.
interface pio_seq_if
   import pio_pkg::*;
   #(parameter int TWIDTH = TWIDTH_DEF)
   ();

   logic              go;
   logic              we;
   logic [TWIDTH-1:0] t1;
   logic [TWIDTH-1:0] t2;
   logic [TWIDTH-1:0] teoc;
   logic              iordy_en;
   logic              iordy;
   logic              busy;
   logic              dior;
   logic              diow;
   logic              oe;
   logic              rd_stb;
   logic              done;

   modport master (
      output go, we, t1, t2, teoc, iordy_en, iordy,
      input  busy, dior, diow, oe, rd_stb, done
   );

   modport slave (
      input  go, we, t1, t2, teoc, iordy_en, iordy,
      output busy, dior, diow, oe, rd_stb, done
   );

endinterface

// File: rtl/pio_tmr.sv
// Loadable phase down-counter. A load of D gives D+1 cycles until and
// including the cycle where zero is high; the count parks at 0.
module pio_tmr
   import pio_pkg::*;
   #(parameter int TWIDTH = TWIDTH_DEF)
   (
      input  logic              clk,
      input  logic              rst,
      input  logic              ld,
      input  logic [TWIDTH-1:0] d,
      output logic              zero
   );

   localparam logic [TWIDTH-1:0] ONE = TWIDTH'(1);

   logic [TWIDTH-1:0] cnt_q;
   logic [TWIDTH-1:0] cnt_d;

   // Load wins; otherwise count down and stop at zero (no wrap).
   always_comb begin
      cnt_d = cnt_q;
      if (ld) begin
         cnt_d = d;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - ONE;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pio_seq.sv
// ATA PIO cycle sequencer: T1 setup, T2 strobe, optional IORDY stretch,
// end-of-cycle recovery. One shared timer is reloaded at each phase entry.
module pio_seq
   import pio_pkg::*;
   #(parameter int TWIDTH = TWIDTH_DEF)
   (
      input  logic     clk,
      input  logic     rst,
      pio_seq_if.slave bus
   );

   pio_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic              ien_q, ien_d;
   logic [TWIDTH-1:0] t2_q, t2_d;
   logic [TWIDTH-1:0] teoc_q, teoc_d;
   logic              sync1_q, sync1_d;
   logic              iordy_s_q, iordy_s_d;
   logic              busy_q, busy_d;
   logic              dior_q, dior_d;
   logic              diow_q, diow_d;
   logic              oe_q, oe_d;
   logic              strobe_d;
   logic              stretch;
   logic              ld;
   logic [TWIDTH-1:0] ld_val;
   logic              zero;

   pio_tmr #(.TWIDTH(TWIDTH)) u_tmr (
      .clk  (clk),
      .rst  (rst),
      .ld   (ld),
      .d    (ld_val),
      .zero (zero)
   );

   // Device is holding the cycle off: only matters when IORDY is honoured.
   assign stretch = ien_q & ~iordy_s_q;

   // Next-state, capture and timer-load decisions; strobes follow the next state.
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      ien_d     = ien_q;
      t2_d      = t2_q;
      teoc_d    = teoc_q;
      ld        = 1'b0;
      ld_val    = '0;
      sync1_d   = bus.iordy;
      iordy_s_d = sync1_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.go) begin
               we_d    = bus.we;
               ien_d   = bus.iordy_en;
               t2_d    = bus.t2;
               teoc_d  = bus.teoc;
               ld      = 1'b1;
               ld_val  = bus.t1;
               state_d = ST_T1;
            end
         end
         ST_T1: begin
            if (zero) begin
               ld      = 1'b1;
               ld_val  = t2_q;
               state_d = ST_T2;
            end
         end
         ST_T2: begin
            if (zero) begin
               if (stretch) begin
                  state_d = ST_WAIT;
               end else begin
                  ld      = 1'b1;
                  ld_val  = teoc_q;
                  state_d = ST_EOC;
               end
            end
         end
         ST_WAIT: begin
            if (iordy_s_q) begin
               ld      = 1'b1;
               ld_val  = teoc_q;
               state_d = ST_EOC;
            end
         end
         ST_EOC: begin
            if (zero) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d   = (state_d != ST_IDLE);
      strobe_d = (state_d == ST_T2) || (state_d == ST_WAIT);
      dior_d   = strobe_d & ~we_d;
      diow_d   = strobe_d & we_d;
      oe_d     = busy_d & we_d;
   end

   // State, captured parameters, IORDY synchronizer and pad-facing outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         we_q      <= 1'b0;
         ien_q     <= 1'b0;
         t2_q      <= '0;
         teoc_q    <= '0;
         sync1_q   <= 1'b0;
         iordy_s_q <= 1'b0;
         busy_q    <= 1'b0;
         dior_q    <= 1'b0;
         diow_q    <= 1'b0;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         ien_q     <= ien_d;
         t2_q      <= t2_d;
         teoc_q    <= teoc_d;
         sync1_q   <= sync1_d;
         iordy_s_q <= iordy_s_d;
         busy_q    <= busy_d;
         dior_q    <= dior_d;
         diow_q    <= diow_d;
         oe_q      <= oe_d;
      end
   end

   // Pulses are decoded only from flops (state, timer, synchronizer), so
   // they are clean one gate after the edge and vanish with reset.
   assign bus.rd_stb = ~we_q & (((state_q == ST_T2) & zero & ~stretch) |
                                ((state_q == ST_WAIT) & iordy_s_q));
   assign bus.done   = (state_q == ST_EOC) & zero;
   assign bus.busy   = busy_q;
   assign bus.dior   = dior_q;
   assign bus.diow   = diow_q;
   assign bus.oe     = oe_q;

endmodule

// File: tb/tb_pio_seq.sv
// Self-checking bench for pio_seq: per-cycle comparison of all outputs
// against a timeline model built from phase lengths.
module tb_pio_seq;
   import pio_pkg::*;

   localparam int TW = 8;
   localparam int N  = 1200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pio_seq_if #(.TWIDTH(TW)) bus ();

   pio_seq #(.TWIDTH(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Per-cycle stimulus for one window.
   bit          go_w    [N];
   bit          we_w    [N];
   bit          ien_w   [N];
   bit          iordy_w [N];
   logic [TW-1:0] t1_w  [N];
   logic [TW-1:0] t2_w  [N];
   logic [TW-1:0] teoc_w[N];
   // Output vectors {busy, dior, diow, oe, rd_stb, done}.
   logic [5:0]  exp_w   [N];
   logic [5:0]  obs_w   [N];
   int          xfers;

   function automatic logic [5:0] outs();
      return {bus.busy, bus.dior, bus.diow, bus.oe, bus.rd_stb, bus.done};
   endfunction

   // Synchronized IORDY seen by the sequencer in cycle x (two cycles late).
   function automatic bit ios(input int x);
      if (x >= 2 && x < N) return iordy_w[x - 2];
      return 1'b0;
   endfunction

   // Idle window: no go, random noise on every other input.
   task automatic fill_noise(input int len);
      for (int r = 0; r < len; r++) begin
         go_w[r]    = 1'b0;
         we_w[r]    = 1'($urandom_range(0, 1));
         ien_w[r]   = 1'($urandom_range(0, 1));
         iordy_w[r] = 1'($urandom_range(0, 1));
         t1_w[r]    = TW'($urandom);
         t2_w[r]    = TW'($urandom);
         teoc_w[r]  = TW'($urandom);
      end
   endtask

   // Reference timeline: each accepted go lays out T1, T2, stretch, EOC.
   function automatic void build_exp(input int len);
      int last_done = -1;
      int s1, s2, e2, se, dn, x;
      bit w;
      xfers = 0;
      for (int r = 0; r < len; r++) exp_w[r] = '0;
      for (int c = 0; c < len; c++) begin
         if (go_w[c] && c > last_done) begin
            w  = we_w[c];
            s1 = c + 1;
            s2 = s1 + int'(t1_w[c]) + 1;
            e2 = s2 + int'(t2_w[c]);
            se = e2;
            if (ien_w[c] && !ios(e2)) begin
               x = e2 + 1;
               while (x < N && !ios(x)) x++;
               se = x;
            end
            dn = se + 1 + int'(teoc_w[c]);
            for (int r = s1; r <= dn && r < len; r++) begin
               exp_w[r][5] = 1'b1;
               exp_w[r][2] = w;
            end
            for (int r = s2; r <= se && r < len; r++) begin
               if (w) exp_w[r][3] = 1'b1;
               else   exp_w[r][4] = 1'b1;
            end
            if (!w && se < len) exp_w[se][1] = 1'b1;
            if (dn < len) exp_w[dn][0] = 1'b1;
            last_done = dn;
            xfers++;
         end
      end
   endfunction

   // Drive one window cycle by cycle and record outputs mid-cycle.
   task automatic run_window(input int len);
      @(posedge clk);
      #1;
      for (int r = 0; r < len; r++) begin
         bus.go       = go_w[r];
         bus.we       = we_w[r];
         bus.iordy_en = ien_w[r];
         bus.iordy    = iordy_w[r];
         bus.t1       = t1_w[r];
         bus.t2       = t2_w[r];
         bus.teoc     = teoc_w[r];
         @(negedge clk);
         obs_w[r] = outs();
         if (r < len - 1) begin
            @(posedge clk);
            #1;
         end
      end
      bus.go = 1'b0;
   endtask

   task automatic test_reset();
      bus.go = 1'b1; bus.we = 1'b1; bus.iordy_en = 1'b0; bus.iordy = 1'b0;
      bus.t1 = '0; bus.t2 = '0; bus.teoc = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if (outs() !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_hold got %b exp %b", outs(), 6'b0);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.go = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (outs() !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_release got %b exp %b", outs(), 6'b0);
      end
      $display("[TB] reset: outputs held low");
   endtask

   // Directed transfers from the block's timing examples plus all-ones lengths.
   task automatic test_directed();
      // {we, t1, t2, teoc, ien, iordy high from cycle}
      int tab [7][6] = '{
         '{1, 2,   5,   1,   0, 9999},
         '{0, 2,   5,   1,   0, 9999},
         '{0, 2,   5,   1,   1, 13},
         '{1, 0,   0,   0,   0, 9999},
         '{0, 0,   255, 1,   0, 9999},
         '{1, 255, 0,   255, 1, 0},
         '{1, 1,   3,   2,   1, 20}
      };
      int len;
      for (int i = 0; i < 7; i++) begin
         len = tab[i][1] + tab[i][2] + tab[i][3] + 40;
         fill_noise(len);
         for (int r = 0; r < len; r++) iordy_w[r] = (r >= tab[i][5]);
         go_w[0]   = 1'b1;
         we_w[0]   = 1'(tab[i][0]);
         t1_w[0]   = TW'(tab[i][1]);
         t2_w[0]   = TW'(tab[i][2]);
         teoc_w[0] = TW'(tab[i][3]);
         ien_w[0]  = 1'(tab[i][4]);
         build_exp(len);
         run_window(len);
         for (int r = 0; r < len; r++) begin
            n_tests++;
            if (obs_w[r] !== exp_w[r]) begin
               n_fail++;
               $display("FAIL directed%0d cyc %0d got %b exp %b", i, r, obs_w[r], exp_w[r]);
            end
         end
         if (i == 0) begin
            n_tests++;
            if (obs_w[11] !== 6'b100101 || obs_w[12] !== 6'b000000) begin
               n_fail++;
               $display("FAIL write_done_cyc11 got %b/%b exp 100101/000000", obs_w[11], obs_w[12]);
            end
         end
         if (i == 2) begin
            n_tests++;
            if (obs_w[15] !== 6'b110010 || obs_w[17] !== 6'b100001) begin
               n_fail++;
               $display("FAIL iordy_exit got %b/%b exp 110010/100001", obs_w[15], obs_w[17]);
            end
         end
         $display("[TB] directed %0d: we=%0d t1=%0d t2=%0d teoc=%0d ien=%0d", i,
                  tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4]);
      end
   endtask

   // go pulses during a transfer (including its done cycle) must be dropped.
   task automatic test_back_to_back();
      int len = 40;
      int gos [4] = '{0, 3, 11, 12};
      fill_noise(len);
      for (int k = 0; k < 4; k++) begin
         go_w[gos[k]]   = 1'b1;
         we_w[gos[k]]   = (k != 1);
         t1_w[gos[k]]   = TW'(2);
         t2_w[gos[k]]   = TW'(5);
         teoc_w[gos[k]] = TW'(1);
         ien_w[gos[k]]  = 1'b0;
      end
      build_exp(len);
      run_window(len);
      for (int r = 0; r < len; r++) begin
         n_tests++;
         if (obs_w[r] !== exp_w[r]) begin
            n_fail++;
            $display("FAIL back_to_back cyc %0d got %b exp %b", r, obs_w[r], exp_w[r]);
         end
      end
      n_tests++;
      if (obs_w[12] !== 6'b000000 || obs_w[13] !== 6'b100100) begin
         n_fail++;
         $display("FAIL go_after_done got %b/%b exp 000000/100100", obs_w[12], obs_w[13]);
      end
      $display("[TB] back_to_back: %0d transfers accepted of 4 go pulses", xfers);
   endtask

   // Reset during T2 kills the cycle at once; a fresh transfer then runs.
   task automatic test_rst_mid();
      int len = 30;
      @(posedge clk);
      #1;
      bus.go = 1'b1; bus.we = 1'b1; bus.iordy_en = 1'b0;
      bus.t1 = TW'(2); bus.t2 = TW'(5); bus.teoc = TW'(1);
      @(posedge clk);
      #1;
      bus.go = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (outs() !== 6'b101100) begin
         n_fail++;
         $display("FAIL pre_rst_t2 got %b exp %b", outs(), 6'b101100);
      end
      #1;
      rst = 1'b1;
      #1;
      n_tests++;
      if (outs() !== 6'b0) begin
         n_fail++;
         $display("FAIL rst_immediate got %b exp %b", outs(), 6'b0);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if (outs() !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_hold got %b exp %b", outs(), 6'b0);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      fill_noise(len);
      go_w[0] = 1'b1; we_w[0] = 1'b0; ien_w[0] = 1'b0;
      t1_w[0] = TW'(2); t2_w[0] = TW'(5); teoc_w[0] = TW'(1);
      build_exp(len);
      run_window(len);
      for (int r = 0; r < len; r++) begin
         n_tests++;
         if (obs_w[r] !== exp_w[r]) begin
            n_fail++;
            $display("FAIL post_rst cyc %0d got %b exp %b", r, obs_w[r], exp_w[r]);
         end
      end
      $display("[TB] rst_mid: transfer aborted, fresh read transfer run");
   endtask

   // Random parameters, random extra go pulses and noisy IORDY.
   task automatic test_random();
      int len = 100;
      for (int k = 0; k < 25; k++) begin
         fill_noise(len);
         for (int r = 0; r < len; r++)
            iordy_w[r] = (r >= 60) ? 1'b1 : ($urandom_range(0, 3) == 0);
         go_w[0] = 1'b1;
         for (int r = 0; r < len; r++) begin
            if (r > 0 && r < 50 && $urandom_range(0, 9) == 0) go_w[r] = 1'b1;
            if (go_w[r]) begin
               t1_w[r]   = TW'($urandom_range(0, 7));
               t2_w[r]   = TW'($urandom_range(0, 7));
               teoc_w[r] = TW'($urandom_range(0, 7));
            end
         end
         build_exp(len);
         run_window(len);
         for (int r = 0; r < len; r++) begin
            n_tests++;
            if (obs_w[r] !== exp_w[r]) begin
               n_fail++;
               $display("FAIL random%0d cyc %0d got %b exp %b", k, r, obs_w[r], exp_w[r]);
            end
         end
         $display("[TB] random %0d: %0d transfers, first we=%0d ien=%0d", k, xfers, we_w[0], ien_w[0]);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_rst_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
